// File: rtl/nrisc_pkg.sv
// -----------------------------------------------------------------------------
// nrisc_pkg
// Shared definitions for the nRisc 8-bit multi-cycle control path:
//   - opcode codes (OP_LOAD .. OP_HALT) and the opcode field position
//   - sequencer state codes (estado_t)
//   - PCSrc selector codes (PC_MAIS1, PC_BEQ, PC_JUMP)
//   - memory-access and branch classification enums produced by the decoder
//   - opcode_de(): extracts the opcode field from an instruction byte
// -----------------------------------------------------------------------------
package nrisc_pkg;

    // Opcode field position inside the 8-bit instruction
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;

    // Opcodes
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_LA    = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_ADDI  = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b101;
    localparam logic [2:0] OP_J     = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // PC source selector
    localparam logic [1:0] PC_MAIS1 = 2'b00;
    localparam logic [1:0] PC_BEQ   = 2'b01;
    localparam logic [1:0] PC_JUMP  = 2'b10;

    // Sequencer states; codes 6 and 7 are illegal
    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    // Data-memory access class of an opcode
    typedef enum logic [1:0] {
        MEM_NENHUM  = 2'd0,
        MEM_LEITURA = 2'd1,
        MEM_ESCRITA = 2'd2
    } mem_t;

    // Control-transfer class of an opcode
    typedef enum logic [1:0] {
        DESVIO_NENHUM = 2'd0,
        DESVIO_BEQ    = 2'd1,
        DESVIO_JUMP   = 2'd2
    } desvio_t;

    // Opcode field of an instruction byte
    function automatic logic [2:0] opcode_de(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/sequenciador_multiciclo_decodificador_opcode.sv
// -----------------------------------------------------------------------------
// decodificador_opcode
// Purely combinational classification of a latched opcode.
// Ports:
//   opcode      in   3  latched opcode
//   ula_op      out  3  ALU operation (the opcode itself)
//   ula_src     out  1  1 = immediate operand (LOAD, LA, STORE, ADDI)
//   reg_src     out  1  1 = write-back data from memory/LA path (LOAD, LA)
//   tipo_mem    out     memory access class (none / read / write)
//   tipo_desvio out     control-transfer class (none / BEQ / jump)
// -----------------------------------------------------------------------------
module decodificador_opcode
    import nrisc_pkg::*;
(
    input  logic [2:0] opcode,
    output logic [2:0] ula_op,
    output logic       ula_src,
    output logic       reg_src,
    output mem_t       tipo_mem,
    output desvio_t    tipo_desvio
);

    // Opcode to operand / write-back / memory / branch class
    always_comb begin
        ula_op      = opcode;
        ula_src     = 1'b0;
        reg_src     = 1'b0;
        tipo_mem    = MEM_NENHUM;
        tipo_desvio = DESVIO_NENHUM;
        case (opcode)
            OP_LOAD: begin
                ula_src  = 1'b1;
                reg_src  = 1'b1;
                tipo_mem = MEM_LEITURA;
            end
            OP_LA: begin
                ula_src = 1'b1;
                reg_src = 1'b1;
            end
            OP_STORE: begin
                ula_src  = 1'b1;
                tipo_mem = MEM_ESCRITA;
            end
            OP_ADD: begin
                ula_src = 1'b0;
            end
            OP_ADDI: begin
                ula_src = 1'b1;
            end
            OP_BEQ: begin
                tipo_desvio = DESVIO_BEQ;
            end
            OP_J: begin
                tipo_desvio = DESVIO_JUMP;
            end
            OP_HALT: begin
                ula_src = 1'b0;
            end
            default: begin
                ula_src     = 1'b0;
                reg_src     = 1'b0;
                tipo_mem    = MEM_NENHUM;
                tipo_desvio = DESVIO_NENHUM;
            end
        endcase
    end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// -----------------------------------------------------------------------------
// sequenciador_multiciclo
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the nRisc
// 8-bit CPU, with data-memory ready handshake, HALT/Start and a saturating
// retired-instruction counter.
// Ports:
//   Clock, Reset (async, active-low)
//   Instrucao[7:0]  instruction byte, opcode in [7:5]
//   Zero            ALU zero flag (BEQ)
//   MemReady        data memory done with current access
//   Start           resume from PARADO
//   IRWrite, PCWrite, PCSrc[1:0], RegWrite, RegSrc, ULASrc, ULAOp[2:0],
//   WE, MemRead     datapath enables
//   Halted          high in PARADO
//   Estado[2:0]     current state code
//   InstrCount      retired instructions, saturating
// Parameters:
//   CNT_W        counter width
//   RESET_HALTED 0 = leave reset in BUSCA, 1 = leave reset in PARADO
// -----------------------------------------------------------------------------
module sequenciador_multiciclo
    import nrisc_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [7:0]       Instrucao,
    input  logic             Zero,
    input  logic             MemReady,
    input  logic             Start,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             RegWrite,
    output logic             RegSrc,
    output logic             ULASrc,
    output logic [2:0]       ULAOp,
    output logic             WE,
    output logic             MemRead,
    output logic             Halted,
    output logic [2:0]       Estado,
    output logic [CNT_W-1:0] InstrCount
);

    localparam estado_t          ESTADO_INICIAL = RESET_HALTED ? PARADO : BUSCA;
    localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_UM         = {{(CNT_W-1){1'b0}}, 1'b1};

    estado_t          estado_q, estado_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       ula_op_s;
    logic             ula_src_s;
    logic             reg_src_s;
    mem_t             tipo_mem_s;
    desvio_t          tipo_desvio_s;

    logic             pc_write_s;
    logic [1:0]       pc_src_s;
    logic             retira_s;
    logic             ativo_s;

    // Only the opcode field of the instruction matters here
    logic             unused_instr_s;
    assign unused_instr_s = ^Instrucao[OPC_LSB-1:0];

    // Every enable is forced low while Reset is held, whatever the state is
    assign ativo_s = Reset;

    decodificador_opcode u_decodificador_opcode (
        .opcode      (opcode_q),
        .ula_op      (ula_op_s),
        .ula_src     (ula_src_s),
        .reg_src     (reg_src_s),
        .tipo_mem    (tipo_mem_s),
        .tipo_desvio (tipo_desvio_s)
    );

    // Next state, opcode capture, PC update request and retirement strobe
    always_comb begin
        estado_d   = estado_q;
        opcode_d   = opcode_q;
        pc_write_s = 1'b0;
        pc_src_s   = PC_MAIS1;
        retira_s   = 1'b0;
        case (estado_q)
            BUSCA: begin
                opcode_d = opcode_de(Instrucao);
                estado_d = DECODIFICA;
            end
            DECODIFICA: begin
                if (opcode_q == OP_HALT) begin
                    estado_d = PARADO;
                    retira_s = 1'b1;
                end else begin
                    estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                case (tipo_desvio_s)
                    DESVIO_BEQ: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = Zero ? PC_BEQ : PC_MAIS1;
                        estado_d   = BUSCA;
                        retira_s   = 1'b1;
                    end
                    DESVIO_JUMP: begin
                        pc_write_s = 1'b1;
                        pc_src_s   = PC_JUMP;
                        estado_d   = BUSCA;
                        retira_s   = 1'b1;
                    end
                    default: begin
                        if (tipo_mem_s != MEM_NENHUM) begin
                            estado_d = MEMORIA;
                        end else begin
                            estado_d = ESCRITA;
                        end
                    end
                endcase
            end
            MEMORIA: begin
                // Wait indefinitely for the memory handshake
                if (MemReady) begin
                    case (tipo_mem_s)
                        MEM_LEITURA: begin
                            estado_d = ESCRITA;
                        end
                        MEM_ESCRITA: begin
                            pc_write_s = 1'b1;
                            estado_d   = BUSCA;
                            retira_s   = 1'b1;
                        end
                        default: begin
                            estado_d = BUSCA;
                        end
                    endcase
                end else begin
                    estado_d = MEMORIA;
                end
            end
            ESCRITA: begin
                pc_write_s = 1'b1;
                estado_d   = BUSCA;
                retira_s   = 1'b1;
            end
            PARADO: begin
                // Resuming steps the PC past the HALT; not a retirement
                if (Start) begin
                    pc_write_s = 1'b1;
                    estado_d   = BUSCA;
                end else begin
                    estado_d = PARADO;
                end
            end
            default: begin
                estado_d = BUSCA;
            end
        endcase
    end

    // Saturating retired-instruction counter
    always_comb begin
        if (retira_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_UM;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sequencer state, latched opcode and counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q <= ESTADO_INICIAL;
            opcode_q <= OP_LOAD;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            estado_q <= estado_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath enables decoded from the state and latched opcode;
    // illegal state codes fall to the all-zero default
    always_comb begin
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegSrc   = 1'b0;
        ULASrc   = 1'b0;
        WE       = 1'b0;
        MemRead  = 1'b0;
        Halted   = 1'b0;
        case (estado_q)
            BUSCA: begin
                IRWrite = ativo_s;
            end
            DECODIFICA, EXECUTA: begin
                ULASrc = ula_src_s;
                RegSrc = reg_src_s;
            end
            MEMORIA: begin
                ULASrc  = ula_src_s;
                RegSrc  = reg_src_s;
                MemRead = ativo_s & (tipo_mem_s == MEM_LEITURA);
                WE      = ativo_s & (tipo_mem_s == MEM_ESCRITA);
            end
            ESCRITA: begin
                ULASrc   = ula_src_s;
                RegSrc   = reg_src_s;
                RegWrite = ativo_s;
            end
            PARADO: begin
                Halted = 1'b1;
            end
            default: begin
                Halted = 1'b0;
            end
        endcase
        if (ativo_s) begin
            PCWrite = pc_write_s;
            PCSrc   = pc_src_s;
        end else begin
            PCWrite = 1'b0;
            PCSrc   = PC_MAIS1;
        end
    end

    assign ULAOp      = ula_op_s;
    assign Estado     = estado_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
module tb_sequenciador_multiciclo;
    import nrisc_pkg::*;

    logic       Clock     = 1'b0;
    logic       Reset     = 1'b0;
    logic [7:0] Instrucao = 8'h00;
    logic       Zero      = 1'b0;
    logic       MemReady  = 1'b0;
    logic       Start     = 1'b0;

    // main instance (CNT_W=16, RESET_HALTED=0)
    logic IRWrite, PCWrite, RegWrite, RegSrc, ULASrc, WE, MemRead, Halted;
    logic [1:0]  PCSrc;
    logic [2:0]  ULAOp, Estado;
    logic [15:0] InstrCount;

    // narrow-counter instance (CNT_W=4)
    logic c4_IRWrite, c4_PCWrite, c4_RegWrite, c4_RegSrc, c4_ULASrc, c4_WE, c4_MemRead, c4_Halted;
    logic [1:0] c4_PCSrc;
    logic [2:0] c4_ULAOp, c4_Estado;
    logic [3:0] c4_InstrCount;

    // boot-halted instance (RESET_HALTED=1)
    logic h_IRWrite, h_PCWrite, h_RegWrite, h_RegSrc, h_ULASrc, h_WE, h_MemRead, h_Halted;
    logic [1:0]  h_PCSrc;
    logic [2:0]  h_ULAOp, h_Estado;
    logic [15:0] h_InstrCount;

    int n_checks  = 0;
    int n_fails   = 0;
    int model_cnt = 0;
    int est_log [1:64];

    sequenciador_multiciclo #(.CNT_W(16), .RESET_HALTED(1'b0)) dut (
        .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .Zero(Zero),
        .MemReady(MemReady), .Start(Start), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .RegSrc(RegSrc), .ULASrc(ULASrc),
        .ULAOp(ULAOp), .WE(WE), .MemRead(MemRead), .Halted(Halted),
        .Estado(Estado), .InstrCount(InstrCount)
    );

    sequenciador_multiciclo #(.CNT_W(4), .RESET_HALTED(1'b0)) dut4 (
        .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .Zero(Zero),
        .MemReady(MemReady), .Start(Start), .IRWrite(c4_IRWrite), .PCWrite(c4_PCWrite),
        .PCSrc(c4_PCSrc), .RegWrite(c4_RegWrite), .RegSrc(c4_RegSrc), .ULASrc(c4_ULASrc),
        .ULAOp(c4_ULAOp), .WE(c4_WE), .MemRead(c4_MemRead), .Halted(c4_Halted),
        .Estado(c4_Estado), .InstrCount(c4_InstrCount)
    );

    sequenciador_multiciclo #(.CNT_W(16), .RESET_HALTED(1'b1)) dut_h (
        .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .Zero(Zero),
        .MemReady(MemReady), .Start(Start), .IRWrite(h_IRWrite), .PCWrite(h_PCWrite),
        .PCSrc(h_PCSrc), .RegWrite(h_RegWrite), .RegSrc(h_RegSrc), .ULASrc(h_ULASrc),
        .ULAOp(h_ULAOp), .WE(h_WE), .MemRead(h_MemRead), .Halted(h_Halted),
        .Estado(h_Estado), .InstrCount(h_InstrCount)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles from entering BUSCA until back in BUSCA (PARADO for HALT)
    function automatic int lat_of(input logic [2:0] op, input int waits);
        case (op)
            OP_BEQ, OP_J: return 3;
            OP_LOAD:      return 5 + waits;
            OP_STORE:     return 4 + waits;
            OP_HALT:      return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic int sat4(input int c);
        return (c > 15) ? 15 : c;
    endfunction

    // Run one instruction from BUSCA (caller is 1 time unit after a rising edge)
    task automatic run_instr(input logic [2:0] op, input logic zero_v, input int waits);
        int lat, n_irw, n_pcw, pcw_cyc, n_rw, n_we, n_mr, n_halt, ula_bad, src_bad;
        int exp_rw;
        logic [1:0] pcsrc_at, exp_pcsrc;
        logic rs_at, exp_src, is_mem;
        string t;
        t = $sformatf("op%0d", op);
        lat = lat_of(op, waits);
        n_irw = 0; n_pcw = 0; pcw_cyc = 0; n_rw = 0; n_we = 0; n_mr = 0;
        n_halt = 0; ula_bad = 0; src_bad = 0;
        pcsrc_at = 2'b00; rs_at = 1'b0;
        exp_src = (op == OP_LOAD) || (op == OP_LA) || (op == OP_STORE) || (op == OP_ADDI);
        is_mem  = (op == OP_LOAD) || (op == OP_STORE);
        exp_rw  = ((op == OP_ADD) || (op == OP_ADDI) || (op == OP_LA) || (op == OP_LOAD)) ? 1 : 0;
        exp_pcsrc = (op == OP_J) ? 2'b10 : ((op == OP_BEQ && zero_v) ? 2'b01 : 2'b00);
        for (int cyc = 1; cyc <= lat; cyc++) begin
            Instrucao = (cyc == 1) ? {op, 5'($urandom)} : 8'($urandom);
            Zero      = (cyc == 3) ? zero_v : 1'($urandom);
            MemReady  = (is_mem && cyc >= 4) ? (cyc == 4 + waits) : 1'($urandom);
            Start     = 1'($urandom);
            @(negedge Clock);
            est_log[cyc] = int'(Estado);
            n_irw  += (IRWrite === 1'b1) ? 1 : 0;
            n_we   += (WE === 1'b1) ? 1 : 0;
            n_mr   += (MemRead === 1'b1) ? 1 : 0;
            n_halt += (Halted === 1'b1) ? 1 : 0;
            if (PCWrite === 1'b1) begin
                n_pcw++;
                pcw_cyc  = cyc;
                pcsrc_at = PCSrc;
            end
            if (RegWrite === 1'b1) begin
                n_rw++;
                rs_at = RegSrc;
            end
            if (cyc >= 2) begin
                if (ULAOp !== op) ula_bad++;
                if (ULASrc !== exp_src) src_bad++;
            end
            @(posedge Clock);
            #1;
        end
        model_cnt++;
        chk({t, "_end_state"}, Estado, (op == OP_HALT) ? 32'd5 : 32'd0);
        chk({t, "_irwrite_cycles"}, n_irw, 1);
        chk({t, "_pcwrite_pulses"}, n_pcw, (op == OP_HALT) ? 0 : 1);
        if (op != OP_HALT) begin
            chk({t, "_pcwrite_cycle"}, pcw_cyc, lat);
            chk({t, "_pcsrc"}, pcsrc_at, exp_pcsrc);
        end
        chk({t, "_regwrite_cycles"}, n_rw, exp_rw);
        if (exp_rw == 1) chk({t, "_regsrc"}, rs_at, ((op == OP_LOAD) || (op == OP_LA)) ? 1 : 0);
        chk({t, "_we_cycles"}, n_we, (op == OP_STORE) ? waits + 1 : 0);
        chk({t, "_memread_cycles"}, n_mr, (op == OP_LOAD) ? waits + 1 : 0);
        chk({t, "_halted_cycles"}, n_halt, 0);
        chk({t, "_ulaop_stable"}, ula_bad, 0);
        chk({t, "_ulasrc"}, src_bad, 0);
        chk({t, "_instrcount"}, InstrCount, model_cnt);
        chk({t, "_instrcount4"}, c4_InstrCount, sat4(model_cnt));
    endtask

    int exp_seq [0:3];

    initial begin
        exp_seq = '{0, 1, 2, 4};

        // Reset values
        Reset = 1'b0; Instrucao = 8'h60; MemReady = 1'b1; Zero = 1'b0; Start = 1'b0;
        #12;
        chk("rst_outs", {IRWrite, PCWrite, PCSrc, RegWrite, RegSrc, ULASrc, ULAOp, WE, MemRead, Halted}, 0);
        chk("rst_state", Estado, 0);
        chk("rst_cnt", InstrCount, 0);
        chk("rst_halted_boot_state", h_Estado, 5);
        chk("rst_halted_boot_flags", {h_Halted, h_PCWrite, h_IRWrite}, 3'b100);

        // Boot-halted instance: first Start pulses PCWrite; main ignores Start
        @(posedge Clock); #1;
        Reset = 1'b1; Start = 1'b1;
        @(negedge Clock);
        chk("boot_start_pulse", {h_PCWrite, h_PCSrc, h_Halted}, 4'b1001);
        chk("main_busca_start_ignored", {IRWrite, PCWrite}, 2'b10);
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("boot_start_state", h_Estado, 0);
        chk("boot_start_nocount", h_InstrCount, 0);

        // Re-reset then directed ADD with state trace
        Reset = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        model_cnt = 0;
        run_instr(OP_ADD, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("add_state_c%0d", i + 1), est_log[i + 1], exp_seq[i]);

        // Directed: LOAD with 3 wait cycles, STORE, BEQ both ways, J, LA, ADDI
        run_instr(OP_LOAD, 1'b0, 3);
        run_instr(OP_STORE, 1'b0, 2);
        run_instr(OP_BEQ, 1'b1, 0);
        run_instr(OP_BEQ, 1'b0, 0);
        run_instr(OP_J, 1'b0, 0);
        run_instr(OP_LA, 1'b0, 0);
        run_instr(OP_ADDI, 1'b1, 0);

        // HALT, hold, resume
        run_instr(OP_HALT, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            Instrucao = 8'($urandom); Zero = 1'($urandom); MemReady = 1'($urandom); Start = 1'b0;
            @(negedge Clock);
            chk("halt_hold", {Estado, Halted, PCWrite, IRWrite, RegWrite, WE, MemRead, InstrCount},
                {3'd5, 1'b1, 5'b00000, 16'(model_cnt)});
            @(posedge Clock); #1;
        end
        Start = 1'b1;
        @(negedge Clock);
        chk("halt_start_pulse", {PCWrite, PCSrc, Halted}, 4'b1001);
        @(posedge Clock); #1;
        Start = 1'b0;
        chk("halt_resume_state", Estado, 0);
        chk("halt_resume_cnt", InstrCount, model_cnt);

        // Reset in the middle of a STORE memory phase
        Instrucao = {OP_STORE, 5'h0A}; MemReady = 1'b0; Start = 1'b0;
        repeat (3) begin
            @(posedge Clock); #1;
            Instrucao = 8'($urandom);
        end
        @(negedge Clock);
        chk("store_mem_we", WE, 1);
        #2 Reset = 1'b0;
        #1;
        chk("rst_async_outs", {IRWrite, PCWrite, PCSrc, RegWrite, RegSrc, ULASrc, ULAOp, WE, MemRead, Halted}, 0);
        chk("rst_async_state", Estado, 0);
        chk("rst_async_cnt", InstrCount, 0);
        chk("rst_async_cnt4", c4_InstrCount, 0);
        model_cnt = 0;
        @(posedge Clock); #1;
        Reset = 1'b1;

        // Saturation of the narrow counter
        for (int i = 0; i < 20; i++) run_instr(OP_ADD, 1'b0, 0);
        chk("sat_cnt4", c4_InstrCount, 15);
        chk("sat_cnt16", InstrCount, 20);

        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            run_instr(3'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
